// File: rtl/bnn_vad_pkg.sv
// Shared types and sizing helpers for the VAD feature front end.
package bnn_vad_pkg;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {IDLE, EMIT} fetch_state_e;

  function automatic int nreg(int frame, int win, int stride);
    return (stride < 1) ? 1 : (frame - win) / stride + 1;
  endfunction

  function automatic int nwin(int frame, int win, int stride, int tail);
    if (stride < 1) return 1;
    return nreg(frame, win, stride) + ((tail != 0 && (frame - win) % stride != 0) ? 1 : 0);
  endfunction

  function automatic int win_start(int k, int frame, int win, int stride, int tail);
    if (tail != 0 && k >= nreg(frame, win, stride)) return frame - win;
    return k * stride;
  endfunction
endpackage

// File: rtl/frame_window_fetch_win_select.sv
// Combinational window mux: picks WIN_LEN consecutive samples starting at start_i.
module win_select import bnn_vad_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = 20,
  parameter int WIN_LEN   = 5,
  parameter int SW        = 5
) (
  input  logic [FRAME_LEN-1:0][DATA_W-1:0] frame_i,
  input  logic [SW-1:0]                    start_i,
  output logic [WIN_LEN-1:0][DATA_W-1:0]   win_o
);
  for (genvar j = 0; j < WIN_LEN; j++) begin : g_lane
    always_comb begin
      win_o[j] = '0;
      for (int i = 0; i <= FRAME_LEN - WIN_LEN; i++)
        if (start_i == SW'(i)) win_o[j] = frame_i[i+j];
    end
  end
endmodule

// File: rtl/frame_window_fetch.sv
// Sliding-window extractor: latches a frame, streams overlapping windows with backpressure.
module frame_window_fetch import bnn_vad_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FRAME_LEN  = 20,
  parameter int WIN_LEN    = 5,
  parameter int STRIDE     = 3,
  parameter int TAIL_ALIGN = 1,
  localparam int NWIN      = nwin(FRAME_LEN, WIN_LEN, STRIDE, TAIL_ALIGN),
  localparam int IDX_W     = $clog2(NWIN + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FRAME_LEN*DATA_W-1:0] in_frame,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIN_LEN*DATA_W-1:0]   out_win,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_first,
  output logic                        out_last
);
  localparam int NREG = nreg(FRAME_LEN, WIN_LEN, STRIDE);
  localparam int SW   = $clog2(FRAME_LEN + 1);
  localparam logic [SW-1:0] TAIL_S = SW'(FRAME_LEN - WIN_LEN);
  localparam logic [SW-1:0] STEP   = SW'(STRIDE);

  if (WIN_LEN > FRAME_LEN || STRIDE < 1 || WIN_LEN < 1) begin : g_bad_cfg
    $error("frame_window_fetch: illegal WIN_LEN/STRIDE/FRAME_LEN combination");
  end

  fetch_state_e                     state_q, state_d;
  logic [FRAME_LEN-1:0][DATA_W-1:0] frame_q, frame_d, sel_frame;
  logic [WIN_LEN-1:0][DATA_W-1:0]   win_q, win_d, sel_win;
  logic [IDX_W-1:0]                 idx_q, idx_d, idx_inc;
  logic [SW-1:0]                    start_q, start_d;
  logic                             acc_in, adv, is_last, load_win;

  assign out_valid = (state_q == EMIT);
  assign is_last   = (idx_q == IDX_W'(NWIN - 1));
  assign adv       = out_valid && out_ready;
  // Ready re-opens on the final handshake so the next frame follows without a bubble.
  assign in_ready  = !flush && ((state_q == IDLE) || (adv && is_last));
  assign acc_in    = in_valid && in_ready;
  assign idx_inc   = idx_q + IDX_W'(1);
  assign out_first = out_valid && (idx_q == '0);
  assign out_last  = out_valid && is_last;
  assign out_idx   = idx_q;
  assign out_win   = win_q;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    start_d   = start_q;
    sel_frame = frame_q;
    load_win  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      start_d = '0;
    end else if (acc_in) begin
      // Window 0 comes straight from the incoming frame; the buffer updates alongside.
      state_d   = EMIT;
      frame_d   = in_frame;
      sel_frame = in_frame;
      idx_d     = '0;
      start_d   = '0;
      load_win  = 1'b1;
    end else if (adv) begin
      if (is_last) begin
        state_d = IDLE;
        idx_d   = '0;
        start_d = '0;
      end else begin
        idx_d    = idx_inc;
        start_d  = (idx_inc == IDX_W'(NREG)) ? TAIL_S : start_q + STEP;
        load_win = 1'b1;
      end
    end
  end

  assign win_d = load_win ? sel_win : win_q;

  win_select #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .WIN_LEN(WIN_LEN), .SW(SW)
  ) u_sel (
    .frame_i(sel_frame),
    .start_i(start_d),
    .win_o  (sel_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      start_q <= start_d;
    end
  end
endmodule

// File: tb/tb_frame_window_fetch.sv
// Four fetcher configurations behind one stimulus/monitor mux, checked against a window-list model.
module tb_frame_window_fetch;
  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [319:0] in_frame = '0;
  int           sel = 0;

  logic [3:0]   iv, rdy, vld, fst, lst;
  logic [79:0]  win0, win1, win2;
  logic [319:0] win3;
  logic [2:0]   idx0, idx1, idx2;
  logic [0:0]   idx3;

  logic         m_vld, m_rdy, m_fst, m_lst;
  logic [319:0] m_win;
  logic [2:0]   m_idx;

  always #5 clk = ~clk;

  always_comb for (int d = 0; d < 4; d++) iv[d] = in_valid && (sel == d);

  frame_window_fetch #(.FRAME_LEN(20), .WIN_LEN(5), .STRIDE(3), .TAIL_ALIGN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[0]), .in_ready(rdy[0]), .in_frame(in_frame),
    .out_valid(vld[0]), .out_ready(out_ready), .out_win(win0), .out_idx(idx0), .out_first(fst[0]), .out_last(lst[0]));
  frame_window_fetch #(.FRAME_LEN(20), .WIN_LEN(5), .STRIDE(4), .TAIL_ALIGN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[1]), .in_ready(rdy[1]), .in_frame(in_frame),
    .out_valid(vld[1]), .out_ready(out_ready), .out_win(win1), .out_idx(idx1), .out_first(fst[1]), .out_last(lst[1]));
  frame_window_fetch #(.FRAME_LEN(20), .WIN_LEN(5), .STRIDE(4), .TAIL_ALIGN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[2]), .in_ready(rdy[2]), .in_frame(in_frame),
    .out_valid(vld[2]), .out_ready(out_ready), .out_win(win2), .out_idx(idx2), .out_first(fst[2]), .out_last(lst[2]));
  frame_window_fetch #(.FRAME_LEN(20), .WIN_LEN(20), .STRIDE(1), .TAIL_ALIGN(1)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv[3]), .in_ready(rdy[3]), .in_frame(in_frame),
    .out_valid(vld[3]), .out_ready(out_ready), .out_win(win3), .out_idx(idx3), .out_first(fst[3]), .out_last(lst[3]));

  always_comb begin
    m_vld = vld[sel[1:0]]; m_rdy = rdy[sel[1:0]]; m_fst = fst[sel[1:0]]; m_lst = lst[sel[1:0]];
    case (sel)
      1:       begin m_win = {240'b0, win1}; m_idx = idx1; end
      2:       begin m_win = {240'b0, win2}; m_idx = idx2; end
      3:       begin m_win = win3;           m_idx = {2'b0, idx3}; end
      default: begin m_win = {240'b0, win0}; m_idx = idx0; end
    endcase
  end

  // Reference: each accepted frame expands into its full list of expected windows.
  typedef struct { logic [319:0] data; int idx; bit first; bit last; } win_t;
  win_t q[$];
  int   cw[4] = '{5, 5, 5, 20};
  int   cs[4] = '{3, 4, 4, 1};
  int   ct[4] = '{1, 1, 0, 1};
  int   n_cmp = 0, n_err = 0, n_acc = 0;
  bit   exp_rdy;

  typedef struct packed { int sel; int k; int start; bit first; bit last; } vec_t;
  vec_t tbl[15];

  task automatic cmp(string nm, logic [319:0] act, logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame(logic [319:0] fr);
    int W, st[$];
    win_t w;
    W = cw[sel];
    for (int s = 0; s <= 20 - W; s += cs[sel]) st.push_back(s);
    if (ct[sel] != 0 && st[st.size()-1] != 20 - W) st.push_back(20 - W);
    foreach (st[k]) begin
      w.data = '0;
      for (int j = 0; j < W; j++) w.data[j*16 +: 16] = fr[(st[k]+j)*16 +: 16];
      w.idx = k; w.first = (k == 0); w.last = (k == st.size() - 1);
      q.push_back(w);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    exp_rdy = !flush && (q.size() == 0 || (out_ready && q[0].last));
    cmp("in_ready", m_rdy, exp_rdy);
    cmp("out_valid", m_vld, q.size() > 0);
    if (q.size() > 0 && m_vld) begin
      cmp("out_win", m_win, q[0].data);
      cmp("out_idx", m_idx, q[0].idx[2:0]);
      cmp("out_first", m_fst, q[0].first);
      cmp("out_last", m_lst, q[0].last);
    end
  endtask

  task automatic tick();
    bit acc, adv;
    acc = in_valid && exp_rdy;
    adv = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (adv) void'(q.pop_front());
      if (acc) begin push_frame(in_frame); n_acc++; end
    end
    #1;
  endtask

  task automatic cycle();
    settle(); tick();
  endtask

  task automatic ramp();
    for (int i = 0; i < 20; i++) in_frame[i*16 +: 16] = 16'(i + 1);
  endtask

  task automatic rand_frame();
    for (int w = 0; w < 10; w++) in_frame[w*32 +: 32] = $urandom;
  endtask

  task automatic check_reset(string nm);
    cmp({nm, "_valid"}, m_vld, 1'b0);
    cmp({nm, "_ready"}, m_rdy, 1'b1);
    cmp({nm, "_idx"}, m_idx, 3'd0);
    cmp({nm, "_first"}, m_fst, 1'b0);
    cmp({nm, "_last"}, m_lst, 1'b0);
    cmp({nm, "_win"}, m_win, '0);
  endtask

  initial begin
    logic [319:0] exp;
    tbl = '{'{0,0,0,1,0}, '{0,1,3,0,0}, '{0,2,6,0,0}, '{0,3,9,0,0}, '{0,4,12,0,0}, '{0,5,15,0,1},
            '{1,0,0,1,0}, '{1,1,4,0,0}, '{1,2,8,0,0}, '{1,3,12,0,0}, '{1,4,15,0,1},
            '{2,0,0,1,0}, '{2,1,4,0,0}, '{2,2,8,0,0}, '{2,3,12,0,1}};

    #12 check_reset("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed window grids for the default and stride-4 configurations.
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].k == 0) begin
        sel = tbl[i].sel; out_ready = 1'b1; ramp(); in_valid = 1'b1;
        cycle(); in_valid = 1'b0;
      end
      settle();
      exp = '0;
      for (int j = 0; j < 5; j++) exp[j*16 +: 16] = 16'(tbl[i].start + j + 1);
      cmp("tbl_valid", m_vld, 1'b1);
      cmp("tbl_win", m_win, exp);
      cmp("tbl_idx", m_idx, tbl[i].k[2:0]);
      cmp("tbl_first", m_fst, tbl[i].first);
      cmp("tbl_last", m_lst, tbl[i].last);
      tick();
      if (tbl[i].last) begin settle(); cmp("tbl_idle", m_vld, 1'b0); tick(); end
    end

    // Random traffic with stalls and occasional flushes on the default configuration.
    sel = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      out_ready = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 59) == 0);
      rand_frame();
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    cmp("rand_drained", q.size(), 0);

    // Back-to-back frames with in_valid held high.
    n_acc = 0; ramp(); in_valid = 1'b1;
    cycle(); rand_frame();
    for (int c = 0; c < 20 && n_acc < 2; c++) cycle();
    cmp("b2b_accepts", n_acc, 2);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) cycle();

    // Flush while stalled on window 2.
    ramp(); in_valid = 1'b1; cycle(); in_valid = 1'b0;
    cycle(); cycle();
    out_ready = 1'b0; settle(); cmp("fl_idx", m_idx, 3'd2); tick();
    flush = 1'b1; in_valid = 1'b1; settle(); cmp("fl_rdy_blocked", m_rdy, 1'b0); tick();
    flush = 1'b0; in_valid = 1'b0; settle();
    cmp("fl_valid", m_vld, 1'b0); cmp("fl_rdy", m_rdy, 1'b1); tick();
    out_ready = 1'b1; rand_frame(); in_valid = 1'b1; cycle(); in_valid = 1'b0;
    settle(); cmp("fl_restart_idx", m_idx, 3'd0); cmp("fl_restart_vld", m_vld, 1'b1); tick();
    for (int c = 0; c < 8; c++) cycle();

    // Asynchronous reset in the middle of a frame.
    ramp(); in_valid = 1'b1; cycle(); in_valid = 1'b0; out_ready = 1'b0;
    cycle(); cycle();
    #1 rst_n = 1'b0;
    #1 check_reset("arst");
    q.delete();
    @(negedge clk); rst_n = 1'b1;
    cycle(); cycle();

    // Single-window frame: first and last together.
    sel = 3; out_ready = 1'b1; ramp(); in_valid = 1'b1; cycle(); in_valid = 1'b0;
    settle();
    cmp("one_first", m_fst, 1'b1); cmp("one_last", m_lst, 1'b1); cmp("one_win", m_win, in_frame);
    tick();
    for (int c = 0; c < 3; c++) cycle();
    cmp("final_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
